// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//
// Contents:
//   ICACHE_ADDR_W       width of the 18-bit byte address space seen by the cache
//   ICACHE_WORD_W       instruction word width
//   ICACHE_INDEX_BITS   default number of line-index bits
//   icache_state_e      miss FSM state encodings (IDLE, FETCH, LAST)
//   icacheTagBits()     tag width left over once index and byte-offset are removed
//
// Optional feature macro used by the cache: ICACHE_STORAGE_EN.
package icache_pkg;

  localparam int ICACHE_ADDR_W     = 18;
  localparam int ICACHE_WORD_W     = 32;
  localparam int ICACHE_INDEX_BITS = 7;

  typedef enum logic [1:0] {
    ICACHE_IDLE  = 2'd0,
    ICACHE_FETCH = 2'd1,
    ICACHE_LAST  = 2'd2
  } icache_state_e;

  // Tag covers every address bit above the index and the 2-bit byte offset.
  function automatic int icacheTagBits(input int indexBits);
    return ICACHE_ADDR_W - indexBits - 2;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag / valid / data storage for the direct-mapped instruction cache.
//
// Only present when ICACHE_STORAGE_EN is defined; without it the cache
// keeps no lines and this file contributes no module.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, clears every valid bit
//   rdIndex_i  line index for the asynchronous read port
//   rdValid_o  valid bit of the addressed line
//   rdTag_o    stored tag of the addressed line
//   rdData_o   stored instruction word of the addressed line
//   wrEn_i     write one full line (tag, data, valid=1)
//   wrIndex_i  line being written
//   wrTag_i    tag to store
//   wrData_i   instruction word to store
`ifdef ICACHE_STORAGE_EN
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = icacheTagBits(ICACHE_INDEX_BITS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [INDEX_BITS-1:0]    rdIndex_i,
  output logic                     rdValid_o,
  output logic [TAG_BITS-1:0]      rdTag_o,
  output logic [ICACHE_WORD_W-1:0] rdData_o,
  input  logic                     wrEn_i,
  input  logic [INDEX_BITS-1:0]    wrIndex_i,
  input  logic [TAG_BITS-1:0]      wrTag_i,
  input  logic [ICACHE_WORD_W-1:0] wrData_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]         valid_q;
  logic [TAG_BITS-1:0]      tag_q  [LINES];
  logic [ICACHE_WORD_W-1:0] data_q [LINES];

  // Valid bits are the only state that needs clearing: a line whose valid
  // bit is low is never a hit, so tag and data contents are don't-care.
  // Lines are only ever set here; nothing but reset invalidates them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIndex_i] <= 1'b1;
    end
  end

  // Tag and data are plain memories written once per completed fill.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      tag_q[wrIndex_i]  <= wrTag_i;
      data_q[wrIndex_i] <= wrData_i;
    end
  end

  assign rdValid_o = valid_q[rdIndex_i];
  assign rdTag_o   = tag_q[rdIndex_i];
  assign rdData_o  = data_q[rdIndex_i];

endmodule
`endif

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache that fills misses one
// byte at a time through a shared byte-wide memory controller.
//
// Configuration macro ICACHE_STORAGE_EN:
//   defined   -> lines are kept in icache_array, hits answer combinationally
//   undefined -> no storage, every request runs the miss sequence and the
//                assembled word is presented for the single LAST cycle
//
// Ports:
//   clk_in          clock
//   rst_in          synchronous active-high reset
//   rdy_in          global ready, low freezes all miss progress
//   req_in          fetch request
//   addr_in         byte address of the instruction (bits [1:0] ignored)
//   inst_valid_out  inst_out holds the word at addr_in this cycle
//   inst_out        instruction word, little-endian
//   mem_busy_in     data side owns the memory controller (has priority)
//   mc_re_out       byte read request to the memory controller
//   mc_addr_out     byte address of that read
//   mc_data_in      read data, valid the cycle after the request
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     req_in,
  input  logic [ICACHE_ADDR_W-1:0] addr_in,
  output logic                     inst_valid_out,
  output logic [ICACHE_WORD_W-1:0] inst_out,
  input  logic                     mem_busy_in,
  output logic                     mc_re_out,
  output logic [ICACHE_ADDR_W-1:0] mc_addr_out,
  input  logic [7:0]               mc_data_in
);

  icache_state_e           state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ICACHE_ADDR_W-3:0] missAddr_q, missAddr_d;
  logic [23:0]             asm_q, asm_d;
  logic                    issued_q;

  logic                     hit;
  logic                     abort;
  logic                     fillEn;
  logic [1:0]               prevCnt;
  logic [ICACHE_WORD_W-1:0] fillWord;
  logic [1:0]               unusedAddrLow;

  assign unusedAddrLow = addr_in[1:0];

  // A fill in progress is abandoned whenever the data side takes the memory
  // controller, or the fetch stage stops asking for exactly the missed word.
  assign abort    = mem_busy_in || !req_in ||
                    (addr_in[ICACHE_ADDR_W-1:2] != missAddr_q);
  assign prevCnt  = cnt_q - 2'd1;
  assign fillWord = {mc_data_in, asm_q};

`ifdef ICACHE_STORAGE_EN
  localparam int TAG_BITS = icacheTagBits(INDEX_BITS);

  logic                     rdValid;
  logic [TAG_BITS-1:0]      rdTag;
  logic [ICACHE_WORD_W-1:0] rdData;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .rdIndex_i (addr_in[INDEX_BITS+1:2]),
    .rdValid_o (rdValid),
    .rdTag_o   (rdTag),
    .rdData_o  (rdData),
    .wrEn_i    (fillEn && !rst_in),
    .wrIndex_i (missAddr_q[INDEX_BITS-1:0]),
    .wrTag_i   (missAddr_q[ICACHE_ADDR_W-3:INDEX_BITS]),
    .wrData_i  (fillWord)
  );

  // Hit path is purely combinational so a hit answers in its own cycle,
  // whatever the miss FSM happens to be doing.
  assign hit            = req_in && rdValid &&
                          (rdTag == addr_in[ICACHE_ADDR_W-1:INDEX_BITS+2]);
  assign inst_valid_out = hit;
  assign inst_out       = hit ? rdData : '0;
`else
  logic [INDEX_BITS-1:0] unusedIndex;

  assign unusedIndex    = addr_in[INDEX_BITS+1:2];
  assign hit            = 1'b0;
  assign inst_valid_out = fillEn;
  assign inst_out       = fillEn ? fillWord : '0;
`endif

  // State register. issued_q deliberately follows mc_re_out every cycle,
  // including stalled ones: it records whether mc_data_in currently carries
  // a byte we actually asked for, which is what makes the post-stall replay
  // possible while the FSM itself stays frozen.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ICACHE_IDLE;
      cnt_q      <= '0;
      missAddr_q <= '0;
      asm_q      <= '0;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      missAddr_q <= missAddr_d;
      asm_q      <= asm_d;
      issued_q   <= mc_re_out;
    end
  end

  // Miss sequencer. FETCH issues byte cnt and captures byte cnt-1 returned
  // from the previous cycle; LAST captures byte 3 and completes the line.
  // If the previous cycle issued nothing (we just came out of a stall), the
  // byte we would capture is stale, so the last issued byte is re-requested
  // first and the counter waits one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    missAddr_d  = missAddr_q;
    asm_d       = asm_q;
    mc_re_out   = 1'b0;
    mc_addr_out = '0;
    fillEn      = 1'b0;

    if (rdy_in) begin
      case (state_q)
        ICACHE_IDLE: begin
          if (req_in && !hit && !mem_busy_in) begin
            state_d    = ICACHE_FETCH;
            cnt_d      = 2'd0;
            missAddr_d = addr_in[ICACHE_ADDR_W-1:2];
          end
        end

        ICACHE_FETCH: begin
          if (abort) begin
            state_d = ICACHE_IDLE;
          end else if (cnt_q != 2'd0 && !issued_q) begin
            mc_re_out   = 1'b1;
            mc_addr_out = {missAddr_q, prevCnt};
          end else begin
            mc_re_out   = 1'b1;
            mc_addr_out = {missAddr_q, cnt_q};
            case (cnt_q)
              2'd1:    asm_d[7:0]   = mc_data_in;
              2'd2:    asm_d[15:8]  = mc_data_in;
              2'd3:    asm_d[23:16] = mc_data_in;
              default: asm_d        = asm_q;
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d = ICACHE_LAST;
            end
          end
        end

        ICACHE_LAST: begin
          if (abort) begin
            state_d = ICACHE_IDLE;
          end else if (!issued_q) begin
            mc_re_out   = 1'b1;
            mc_addr_out = {missAddr_q, 2'd3};
          end else begin
            fillEn  = 1'b1;
            state_d = ICACHE_IDLE;
          end
        end

        default: begin
          state_d = ICACHE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache. Inputs change and outputs are sampled in
// the low phase of the clock (1 time unit after the falling edge). The
// memory controller model returns mem[addr] the cycle after a read request
// and 8'hEE in any cycle that follows no request.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        req_in;
  logic [17:0] addr_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic        mem_busy_in;
  logic        mc_re_out;
  logic [17:0] mc_addr_out;
  logic [7:0]  mc_data_in;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [1024];

  always #5 clk_in = ~clk_in;

  icache #(.INDEX_BITS(7)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_in         (req_in),
    .addr_in        (addr_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .mem_busy_in    (mem_busy_in),
    .mc_re_out      (mc_re_out),
    .mc_addr_out    (mc_addr_out),
    .mc_data_in     (mc_data_in)
  );

  // Byte-wide memory controller with one cycle of read latency.
  always @(posedge clk_in) begin
    mc_data_in <= mc_re_out ? mem[mc_addr_out[9:0]] : 8'hEE;
  end

  // Drive one cycle's inputs in the low phase and let them settle.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic req,
                               input logic [17:0] addr, input logic busy);
    @(negedge clk_in);
    rst_in      = rst;
    rdy_in      = rdy;
    req_in      = req;
    addr_in     = addr;
    mem_busy_in = busy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 18'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16] = 8'h13;
    mem[17] = 8'h05;
    mem[18] = 8'h10;
    mem[19] = 8'h00;
    rst_in = 1'b1; rdy_in = 1'b1; req_in = 1'b0; addr_in = '0; mem_busy_in = 1'b0;

    // Reset and the quiet state right after it
    applyStimulus(1'b1, 1'b1, 1'b0, 18'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 18'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h10, 1'b0);
    checkOutput("rst_valid", 32'(inst_valid_out), 32'd0);
    checkOutput("rst_inst", inst_out, 32'h0);
    checkOutput("rst_re", 32'(mc_re_out), 32'd0);
    checkOutput("rst_addr", 32'(mc_addr_out), 32'h0);

    // First miss on 0x00010: bytes 0x10..0x13 at T+1..T+4
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("m1_T_valid", 32'(inst_valid_out), 32'd0);
    checkOutput("m1_T_re", 32'(mc_re_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
      checkOutput("m1_re", 32'(mc_re_out), 32'd1);
      checkOutput("m1_addr", 32'(mc_addr_out), 32'h10 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("m1_T5_re", 32'(mc_re_out), 32'd0);
`ifdef ICACHE_STORAGE_EN
    checkOutput("m1_T5_valid", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("m1_T6_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("m1_T6_inst", inst_out, 32'h00100513);
    checkOutput("m1_T6_re", 32'(mc_re_out), 32'd0);
    // Same address again is a same-cycle hit with no memory traffic
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("hit_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("hit_inst", inst_out, 32'h00100513);
    checkOutput("hit_re", 32'(mc_re_out), 32'd0);
`else
    checkOutput("m1_T5_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("m1_T5_inst", inst_out, 32'h00100513);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("m1_T6_valid", 32'(inst_valid_out), 32'd0);
    checkOutput("m1_T6_re", 32'(mc_re_out), 32'd0);
    // Without storage the repeated request simply refetches
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("rep_re", 32'(mc_re_out), 32'd1);
    checkOutput("rep_addr", 32'(mc_addr_out), 32'h10);
`endif
    idleCycles(2);

    // Conflicting tag on the same index: 0x00210 replaces 0x00010
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h210, 1'b0);
    checkOutput("cf_T_valid", 32'(inst_valid_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 18'h210, 1'b0);
      checkOutput("cf_addr", 32'(mc_addr_out), 32'h210 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h210, 1'b0);
`ifdef ICACHE_STORAGE_EN
    checkOutput("cf_T5_valid", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h210, 1'b0);
    checkOutput("cf_T6_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("cf_T6_inst", inst_out, 32'h49484B4A);
`else
    checkOutput("cf_T5_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("cf_T5_inst", inst_out, 32'h49484B4A);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h210, 1'b0);
    checkOutput("cf_T6_valid", 32'(inst_valid_out), 32'd0);
`endif
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("cf_old_miss", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("cf_old_re", 32'(mc_re_out), 32'd1);
    checkOutput("cf_old_addr", 32'(mc_addr_out), 32'h10);
    idleCycles(2);

    // Data side takes the controller at T+3, then releases it
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("bz_T_valid", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("bz_T2_addr", 32'(mc_addr_out), 32'h11);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b1);
    checkOutput("bz_T3_re", 32'(mc_re_out), 32'd0);
    checkOutput("bz_T3_addr", 32'(mc_addr_out), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("bz_T4_re", 32'(mc_re_out), 32'd0);
    checkOutput("bz_T4_valid", 32'(inst_valid_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
      checkOutput("bz_addr", 32'(mc_addr_out), 32'h10 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
`ifdef ICACHE_STORAGE_EN
    checkOutput("bz_fill_early", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
`endif
    checkOutput("bz_fill_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("bz_fill_inst", inst_out, 32'h00100513);
    idleCycles(2);

    // Address moves from 0x00010 to 0x00044 mid-fetch (after a fresh reset)
    applyStimulus(1'b1, 1'b1, 1'b0, 18'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h44, 1'b0);
    checkOutput("ab_T3_re", 32'(mc_re_out), 32'd0);
    checkOutput("ab_T3_valid", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h44, 1'b0);
    checkOutput("ab_T4_re", 32'(mc_re_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 18'h44, 1'b0);
      checkOutput("ab_addr", 32'(mc_addr_out), 32'h44 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h44, 1'b0);
`ifdef ICACHE_STORAGE_EN
    checkOutput("ab_fill_early", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h44, 1'b0);
`endif
    checkOutput("ab_fill_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("ab_fill_inst", inst_out, 32'h1D1C1F1E);
    idleCycles(2);

    // 0x00010 was never completed, so it misses; this miss also hosts the
    // three-cycle ready stall starting at T+2
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("ab_old_miss", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("st_T1_addr", 32'(mc_addr_out), 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 18'h10, 1'b0);
      checkOutput("st_hold_re", 32'(mc_re_out), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
    checkOutput("st_replay_re", 32'(mc_re_out), 32'd1);
    checkOutput("st_replay_addr", 32'(mc_addr_out), 32'h10);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
      checkOutput("st_addr", 32'(mc_addr_out), 32'h10 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
`ifdef ICACHE_STORAGE_EN
    checkOutput("st_fill_early", 32'(inst_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 1'b0);
`endif
    checkOutput("st_fill_valid", 32'(inst_valid_out), 32'd1);
    checkOutput("st_fill_inst", inst_out, 32'h00100513);
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
